// File: rtl/sum_accum.sv
// rtl/sum_accum.sv - block accumulator for unsigned sum samples with saturation
//
// Purpose: adds BLOCK_LEN consecutive accepted samples (or fewer, when the
// block is closed early by flush) into a saturating accumulator and presents
// the block total, sample count and a saturation flag on a valid/ready
// result port. Only one block is in flight at a time.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rstn       asynchronous reset, active high (name kept from the block interface)
//   in_valid   upstream sample valid
//   in_data    unsigned sample, WIDTH bits
//   in_ready   sample can be taken this cycle (IDLE or ACCUM)
//   flush      close the current partial block early (ignored in IDLE)
//   out_valid  block result valid (DONE)
//   out_ready  downstream takes the result
//   out_data   accumulated block total, ACC_WIDTH bits, 0 outside DONE
//   out_count  number of samples in the block, 0 outside DONE
//   out_ovf    saturation happened within the block, 0 outside DONE

module sum_accum #(
  parameter int WIDTH     = 8,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [7:0]           out_count,
  output logic                 out_ovf
);

  localparam int                 SUM_WIDTH = ACC_WIDTH + 1;
  localparam logic [7:0]         BLEN      = 8'(BLOCK_LEN);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [SUM_WIDTH-1:0] sum_ext;
  logic                 sum_sat;
  logic [7:0]           cnt_inc;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  // One extra bit on the adder so the carry out flags saturation; the
  // accumulator itself never wraps.
  assign sum_ext = {1'b0, acc_q} + SUM_WIDTH'(in_data);
  assign sum_sat = sum_ext[ACC_WIDTH];
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = ACC_WIDTH'(in_data);
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = (BLEN == 8'd1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum_sat ? ACC_MAX : sum_ext[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum_sat;
          cnt_d = cnt_inc;
          // A flush in the same cycle as an accept still counts the sample.
          if (cnt_inc == BLEN || flush) begin
            state_d = DONE;
          end
        end else if (flush) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The result is held untouched until the downstream handshake;
        // in_ready is low here so no sample slips in.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are gated by the registered state so they read zero outside DONE
  // and clear immediately when reset is asserted.
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_count = out_valid ? cnt_q : 8'd0;
  assign out_ovf   = out_valid ? ovf_q : 1'b0;

endmodule

// File: tb/tb_sum_accum.sv
// tb/tb_sum_accum.sv - directed self-checking bench for sum_accum

module tb_sum_accum;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [7:0] out_count;
  logic       out_ovf;

  int checks = 0;
  int errors = 0;

  sum_accum #(.WIDTH(8), .BLOCK_LEN(4), .ACC_WIDTH(9)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int data, input int cnt, input int ovf);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"},  32'(out_data),  32'(data));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    chk({tag, "_inrdy"}, 32'(in_ready),  0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  32'(out_data),  0);
    chk({tag, "_count"}, 32'(out_count), 0);
    chk({tag, "_ovf"},   32'(out_ovf),   0);
  endtask

  initial begin
    rstn      = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset holds outputs at zero before any clock edge.
    #3;
    chk_zero("rst_async");
    tick();
    chk_zero("rst_held");
    rstn = 1'b0;
    #1;
    chk("rst_inrdy", 32'(in_ready), 1);
    tick();
    chk_zero("rst_idle");

    // Back-to-back block 25+40+55+15 = 135.
    out_ready = 1'b1;
    send(8'd25);
    send(8'd40);
    send(8'd55);
    chk("b1_latency", 32'(out_valid), 0);
    send(8'd15);
    chk_result("b1", 135, 4, 0);
    tick();
    chk_zero("b1_idle");
    chk("b1_idle_inrdy", 32'(in_ready), 1);

    // Saturating block: 200+200+100 = 500, +50 clips at 511.
    send(8'd200);
    send(8'd200);
    send(8'd100);
    send(8'd50);
    chk_result("sat", 511, 4, 1);
    tick();
    send(8'd1);
    send(8'd1);
    send(8'd1);
    send(8'd1);
    chk_result("after_sat", 4, 4, 0);
    tick();

    // Backpressure in DONE with a waiting sample.
    out_ready = 1'b0;
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    in_valid = 1'b1;
    in_data  = 8'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_result("bp_hold", 10, 4, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_inrdy", 32'(in_ready), 1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk_result("bp_pending", 9, 1, 0);
    out_ready = 1'b1;
    tick();

    // Flush while IDLE does nothing.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_valid", 32'(out_valid), 0);
    chk("idle_flush_inrdy", 32'(in_ready), 1);

    // Early close by flush alone: 10+20.
    send(8'd10);
    send(8'd20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_result("flush", 30, 2, 0);
    tick();

    // Flush together with an accept: 10+20+5.
    send(8'd10);
    send(8'd20);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd5;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_result("flush_acc", 35, 3, 0);
    tick();

    // Reset mid-block discards 7,8; a sample offered during reset is ignored.
    send(8'd7);
    send(8'd8);
    #2;
    rstn = 1'b1;
    #1;
    chk_zero("mid_rst");
    in_valid = 1'b1;
    in_data  = 8'd99;
    tick();
    chk_zero("mid_rst_edge");
    in_valid = 1'b0;
    rstn     = 1'b0;
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    chk_result("post_rst", 10, 4, 0);

    // Reset while a result is pending in DONE.
    out_ready = 1'b0;
    tick();
    chk("done_hold", 32'(out_valid), 1);
    #2;
    rstn = 1'b1;
    #1;
    chk_zero("done_rst");
    tick();
    rstn = 1'b0;
    tick();
    chk_zero("done_rst_idle");
    chk("done_rst_inrdy", 32'(in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
